// File: rtl/riscv_cov_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_cov_pkg
// Description : Shared class indices, RV64I major opcodes and the monitor
//               state encoding for the instruction coverage monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_cov_pkg;

    localparam int NUM_CLASSES = 12;
    localparam int CLS_W       = 4;

    // Coverage class indices; hit/counter slot numbers follow these.
    localparam logic [CLS_W-1:0] CLS_LUI       = 4'd0;
    localparam logic [CLS_W-1:0] CLS_AUIPC     = 4'd1;
    localparam logic [CLS_W-1:0] CLS_JAL       = 4'd2;
    localparam logic [CLS_W-1:0] CLS_JALR      = 4'd3;
    localparam logic [CLS_W-1:0] CLS_BRANCH    = 4'd4;
    localparam logic [CLS_W-1:0] CLS_LOAD      = 4'd5;
    localparam logic [CLS_W-1:0] CLS_STORE     = 4'd6;
    localparam logic [CLS_W-1:0] CLS_OP_IMM    = 4'd7;
    localparam logic [CLS_W-1:0] CLS_OP        = 4'd8;
    localparam logic [CLS_W-1:0] CLS_OP_IMM_32 = 4'd9;
    localparam logic [CLS_W-1:0] CLS_OP_32     = 4'd10;
    localparam logic [CLS_W-1:0] CLS_ILLEGAL   = 4'd11;

    // Major opcodes, insn[6:0].
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // Monitor state encoding as seen on the state output.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } cov_state_e;

endpackage : riscv_cov_pkg
`default_nettype wire

// File: rtl/riscv_insn_classify.sv
`default_nettype none
// ============================================================================
// Module      : riscv_insn_classify
// Description : Combinational opcode-to-coverage-class decode. Anything the
//               upstream checker flags as invalid, or any opcode outside the
//               eleven tracked groups, lands in the ILLEGAL class.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_insn_classify
    import riscv_cov_pkg::*;
(
    input  logic [6:0]       i_opcode,
    input  logic             i_legal,
    output logic [CLS_W-1:0] o_class
);

    // Opcode lookup, gated by the legality verdict.
    always_comb begin
        o_class = CLS_ILLEGAL;
        if (i_legal) begin
            case (i_opcode)
                OPC_LUI:       o_class = CLS_LUI;
                OPC_AUIPC:     o_class = CLS_AUIPC;
                OPC_JAL:       o_class = CLS_JAL;
                OPC_JALR:      o_class = CLS_JALR;
                OPC_BRANCH:    o_class = CLS_BRANCH;
                OPC_LOAD:      o_class = CLS_LOAD;
                OPC_STORE:     o_class = CLS_STORE;
                OPC_OP_IMM:    o_class = CLS_OP_IMM;
                OPC_OP:        o_class = CLS_OP;
                OPC_OP_IMM_32: o_class = CLS_OP_IMM_32;
                OPC_OP_32:     o_class = CLS_OP_32;
                default:       o_class = CLS_ILLEGAL;
            endcase
        end
    end

endmodule : riscv_insn_classify
`default_nettype wire

// File: rtl/riscv_insn_coverage_mon.sv
`default_nettype none
// ============================================================================
// Module      : riscv_insn_coverage_mon
// Description : Committed-instruction coverage monitor. Accepted words are
//               classified into stage 1 and committed in stage 2 (saturating
//               per-class counters, sticky hit bits, first-illegal capture).
//               Counters are readable one cycle after request in any state.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_insn_coverage_mon
    import riscv_cov_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter bit STOP_ON_ILLEGAL = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   freeze,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [31:0]            in_insn,
    input  logic                   in_legal,
    output logic [NUM_CLASSES-1:0] hit,
    output logic                   all_hit,
    output logic [31:0]            first_illegal,
    output logic                   illegal_seen,
    output logic [1:0]             state,
    input  logic                   rd_req,
    input  logic [3:0]             rd_idx,
    output logic                   rd_ack,
    output logic [CNT_W-1:0]       rd_data
);

    cov_state_e              r_state;
    logic                    r_s1_valid;
    logic [31:0]             r_s1_insn;
    logic [CLS_W-1:0]        r_s1_class;
    logic [CNT_W-1:0]        r_cnt [NUM_CLASSES];
    logic [NUM_CLASSES-1:0]  r_hit;
    logic                    r_illegal_seen;
    logic [31:0]             r_first_illegal;
    logic                    r_rd_ack;
    logic [CNT_W-1:0]        r_rd_data;

    logic [CLS_W-1:0]        w_class;
    logic                    w_accept;
    logic                    w_first_ill_commit;
    logic [CNT_W-1:0]        w_rd_val;

    riscv_insn_classify u_classify (
        .i_opcode (in_insn[6:0]),
        .i_legal  (in_legal),
        .o_class  (w_class)
    );

    assign w_accept           = in_valid && (r_state == ST_RUN);
    assign w_first_ill_commit = r_s1_valid && (r_s1_class == CLS_ILLEGAL) && !r_illegal_seen;

    // Monitor state machine; clear beats everything but reset.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (freeze || (STOP_ON_ILLEGAL && w_first_ill_commit))
                        r_state <= ST_FROZEN;
                end
                ST_FROZEN: r_state <= ST_FROZEN;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Stage 1: register accepted instruction with its decoded class.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_s1_valid <= 1'b0;
            r_s1_insn  <= '0;
            r_s1_class <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_insn  <= in_insn;
                r_s1_class <= w_class;
            end
        end
    end

    // Stage 2 commit: saturating class counters.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            for (int i = 0; i < NUM_CLASSES; i++) r_cnt[i] <= '0;
        end else if (r_s1_valid) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if ((r_s1_class == CLS_W'(i)) && (r_cnt[i] != {CNT_W{1'b1}}))
                    r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    // Stage 2 commit: sticky hit bits and first-illegal capture.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_hit           <= '0;
            r_illegal_seen  <= 1'b0;
            r_first_illegal <= '0;
        end else begin
            if (r_s1_valid) begin
                for (int i = 0; i < NUM_CLASSES; i++) begin
                    if (r_s1_class == CLS_W'(i)) r_hit[i] <= 1'b1;
                end
            end
            if (w_first_ill_commit) begin
                r_illegal_seen  <= 1'b1;
                r_first_illegal <= r_s1_insn;
            end
        end
    end

    // Read mux samples pre-commit counter values; out-of-range reads give 0.
    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (rd_idx == 4'(i)) w_rd_val = r_cnt[i];
        end
    end

    // Read response register, one cycle after request.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ack  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_ack  <= rd_req;
            r_rd_data <= rd_req ? w_rd_val : '0;
        end
    end

    assign hit           = r_hit;
    assign all_hit       = &r_hit[NUM_CLASSES-2:0];
    assign first_illegal = r_first_illegal;
    assign illegal_seen  = r_illegal_seen;
    assign state         = r_state;
    assign rd_ack        = r_rd_ack;
    assign rd_data       = r_rd_data;

endmodule : riscv_insn_coverage_mon
`default_nettype wire

// File: tb/tb_riscv_insn_coverage_mon.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_insn_coverage_mon
// Description : Directed self-checking bench. u0 = defaults, u1 = stop on
//               illegal, u2 = 4-bit counters; all share one stimulus bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_insn_coverage_mon;

    logic        clock = 1'b0;
    logic        reset, enable, freeze, clear;
    logic        in_valid, in_legal, rd_req;
    logic [31:0] in_insn;
    logic [3:0]  rd_idx;

    logic [11:0] u0_hit, u1_hit, u2_hit;
    logic        u0_all, u1_all, u2_all;
    logic [31:0] u0_fi, u1_fi, u2_fi;
    logic        u0_is, u1_is, u2_is;
    logic [1:0]  u0_st, u1_st, u2_st;
    logic        u0_ack, u1_ack, u2_ack;
    logic [15:0] u0_rd, u1_rd;
    logic [3:0]  u2_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    riscv_insn_coverage_mon #(.CNT_W(16), .STOP_ON_ILLEGAL(1'b0)) u0 (
        .clock(clock), .reset(reset), .enable(enable), .freeze(freeze), .clear(clear),
        .in_valid(in_valid), .in_insn(in_insn), .in_legal(in_legal),
        .hit(u0_hit), .all_hit(u0_all), .first_illegal(u0_fi), .illegal_seen(u0_is),
        .state(u0_st), .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(u0_ack), .rd_data(u0_rd));

    riscv_insn_coverage_mon #(.CNT_W(16), .STOP_ON_ILLEGAL(1'b1)) u1 (
        .clock(clock), .reset(reset), .enable(enable), .freeze(freeze), .clear(clear),
        .in_valid(in_valid), .in_insn(in_insn), .in_legal(in_legal),
        .hit(u1_hit), .all_hit(u1_all), .first_illegal(u1_fi), .illegal_seen(u1_is),
        .state(u1_st), .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(u1_ack), .rd_data(u1_rd));

    riscv_insn_coverage_mon #(.CNT_W(4), .STOP_ON_ILLEGAL(1'b0)) u2 (
        .clock(clock), .reset(reset), .enable(enable), .freeze(freeze), .clear(clear),
        .in_valid(in_valid), .in_insn(in_insn), .in_legal(in_legal),
        .hit(u2_hit), .all_hit(u2_all), .first_illegal(u2_fi), .illegal_seen(u2_is),
        .state(u2_st), .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(u2_ack), .rd_data(u2_rd));

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; the DUT samples on the rising edge.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic pulse_enable();
        enable = 1'b1; step(); enable = 1'b0;
    endtask

    task automatic issue(input logic [31:0] insn, input logic legal);
        in_valid = 1'b1; in_insn = insn; in_legal = legal;
        step();
        in_valid = 1'b0; in_legal = 1'b0; in_insn = '0;
    endtask

    // After return the response of all three instances is on their rd_* ports.
    task automatic do_read(input logic [3:0] idx);
        rd_req = 1'b1; rd_idx = idx;
        step();
        rd_req = 1'b0; rd_idx = '0;
    endtask

    logic [31:0] cls_insn [11];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        cls_insn = '{32'h00000037, 32'h00000017, 32'h0000006F, 32'h00000067,
                     32'h00000063, 32'h00003003, 32'h00003023, 32'h00000013,
                     32'h00000033, 32'h0000001B, 32'h0000003B};
        reset = 1'b1; enable = 0; freeze = 0; clear = 0;
        in_valid = 0; in_insn = '0; in_legal = 0; rd_req = 0; rd_idx = '0;
        step();
        do_reset();

        // Reset state.
        chk_eq("rst_state",    32'(u0_st),  32'd0);
        chk_eq("rst_hit",      32'(u0_hit), 32'd0);
        chk_eq("rst_all_hit",  32'(u0_all), 32'd0);
        chk_eq("rst_ill_seen", 32'(u0_is),  32'd0);
        chk_eq("rst_first_il", u0_fi,       32'd0);
        chk_eq("rst_rd_ack",   32'(u0_ack), 32'd0);
        chk_eq("rst_rd_data",  32'(u0_rd),  32'd0);

        // Enable then a single LUI: hit appears two edges after acceptance.
        pulse_enable();
        chk_eq("en_state_run", 32'(u0_st), 32'd1);
        issue(32'h00000037, 1'b1);
        chk_eq("lui_hit_early", 32'(u0_hit[0]), 32'd0);
        step();
        chk_eq("lui_hit", 32'(u0_hit[0]), 32'd1);
        do_read(4'd0);
        chk_eq("lui_rd_ack", 32'(u0_ack), 32'd1);
        chk_eq("lui_rd_cnt", 32'(u0_rd),  32'd1);

        // Illegal capture; a second illegal leaves the first word in place.
        issue(32'h00007003, 1'b0);
        step();
        chk_eq("ill_seen",  32'(u0_is), 32'd1);
        chk_eq("ill_first", u0_fi,      32'h00007003);
        do_read(4'd11);
        chk_eq("ill_cnt1",  32'(u0_rd), 32'd1);
        chk_eq("ill_load_not_hit", 32'(u0_hit[5]), 32'd0);
        issue(32'hFFFFFFFF, 1'b1);
        step();
        chk_eq("ill_first_kept", u0_fi, 32'h00007003);
        do_read(4'd11);
        chk_eq("ill_cnt2",  32'(u0_rd), 32'd2);

        // Read sampled in the same cycle as an ADDI commit returns the old value.
        in_valid = 1'b1; in_insn = 32'h00000013; in_legal = 1'b1;
        step();
        in_valid = 1'b0; in_legal = 1'b0; in_insn = '0;
        rd_req = 1'b1; rd_idx = 4'd7;
        step();
        rd_req = 1'b0;
        chk_eq("race_rd_ack", 32'(u0_ack), 32'd1);
        chk_eq("race_rd_old", 32'(u0_rd),  32'd0);
        do_read(4'd7);
        chk_eq("race_rd_new", 32'(u0_rd),  32'd1);
        do_read(4'd13);
        chk_eq("oor13_ack",  32'(u0_ack), 32'd1);
        chk_eq("oor13_data", 32'(u0_rd),  32'd0);
        do_read(4'd12);
        chk_eq("oor12_data", 32'(u0_rd),  32'd0);

        // One of every legal class gives all_hit; clear wipes everything.
        for (int i = 0; i < 11; i++) issue(cls_insn[i], 1'b1);
        step();
        chk_eq("all_hit",  32'(u0_all), 32'd1);
        chk_eq("hit_full", 32'(u0_hit), 32'h00000FFF);
        do_read(4'd7);
        chk_eq("opimm_cnt", 32'(u0_rd), 32'd2);
        clear = 1'b1; step(); clear = 1'b0;
        chk_eq("clr_state",   32'(u0_st),  32'd0);
        chk_eq("clr_hit",     32'(u0_hit), 32'd0);
        chk_eq("clr_all_hit", 32'(u0_all), 32'd0);
        chk_eq("clr_ill",     32'(u0_is),  32'd0);
        chk_eq("clr_first",   u0_fi,       32'd0);
        chk_eq("clr_rd_ack",  32'(u0_ack), 32'd0);
        chk_eq("clr_rd_data", 32'(u0_rd),  32'd0);
        do_read(4'd7);
        chk_eq("clr_cnt7", 32'(u0_rd), 32'd0);

        // Freeze in IDLE ignored; freeze cycle acceptance drains; FROZEN ignores enable.
        freeze = 1'b1; step(); freeze = 1'b0;
        chk_eq("frz_idle_ign", 32'(u0_st), 32'd0);
        pulse_enable();
        in_valid = 1'b1; in_insn = 32'h00000013; in_legal = 1'b1; freeze = 1'b1;
        step();
        in_valid = 1'b0; in_legal = 1'b0; freeze = 1'b0;
        chk_eq("frz_state", 32'(u0_st), 32'd2);
        step();
        issue(32'h00000013, 1'b1);
        step();
        do_read(4'd7);
        chk_eq("frz_drain_cnt", 32'(u0_rd), 32'd1);
        pulse_enable();
        chk_eq("frz_en_ign", 32'(u0_st), 32'd2);

        // Stop-on-illegal: back-to-back ADDI still commits, then inputs ignored.
        do_reset();
        pulse_enable();
        issue(32'h00007003, 1'b0);
        issue(32'h00000013, 1'b1);
        chk_eq("soi_state",   32'(u1_st), 32'd2);
        chk_eq("soi_u0_run",  32'(u0_st), 32'd1);
        step();
        chk_eq("soi_first",   u1_fi, 32'h00007003);
        issue(32'h00000037, 1'b1);
        issue(32'h00000013, 1'b1);
        step();
        do_read(4'd7);
        chk_eq("soi_addi_cnt", 32'(u1_rd), 32'd1);
        do_read(4'd0);
        chk_eq("soi_lui_ign",  32'(u1_rd), 32'd0);
        do_read(4'd11);
        chk_eq("soi_ill_cnt",  32'(u1_rd), 32'd1);

        // Saturation: 20 ADDIs into a 4-bit counter.
        do_reset();
        pulse_enable();
        for (int i = 0; i < 20; i++) issue(32'h00000013, 1'b1);
        step();
        do_read(4'd7);
        chk_eq("sat_u2_cnt", 32'(u2_rd), 32'd15);
        chk_eq("sat_u0_cnt", 32'(u0_rd), 32'd20);
        chk_eq("sat_u2_hit", 32'(u2_hit), 32'h00000080);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_riscv_insn_coverage_mon
`default_nettype wire
